// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared CPU pipeline types for the hazard controller.
package pipe_hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, ERROR = 2'd3} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: load-use compare between the load in EX and the sources in ID.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);
  // x0 is hard-wired, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/reg_arstn.sv
// reg_arstn: generic register with asynchronous active-low reset to a parameterised value.
module reg_arstn #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) q <= RST;
    else q <= d;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline register enable/flush sequencing for load-use, branch and memory-wait hazards.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 2,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  mem_timeout
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [1:0]       state, nstate;
  logic [HW-1:0]    hold, nhold;
  logic [WW-1:0]    wcnt, nwcnt;
  logic [CNT_W-1:0] ncnt;
  logic             nto, load_use, frozen;
  pipe_hazard_ctrl_hazard_detect u_hd (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .load_use(load_use)
  );
  reg_arstn #(.W(2), .RST(HOLD)) u_state (.clk(clk), .arst_n(arst_n), .d(nstate), .q(state));
  reg_arstn #(.W(HW), .RST(HW'(RST_HOLD - 1))) u_hold (.clk(clk), .arst_n(arst_n), .d(nhold), .q(hold));
  reg_arstn #(.W(WW)) u_wait (.clk(clk), .arst_n(arst_n), .d(nwcnt), .q(wcnt));
  reg_arstn #(.W(CNT_W)) u_cnt (.clk(clk), .arst_n(arst_n), .d(ncnt), .q(stall_cnt));
  reg_arstn #(.W(1)) u_to (.clk(clk), .arst_n(arst_n), .d(nto), .q(mem_timeout));
  // once waiting, only mem_ready matters; the stalled access is still the one in MEM
  assign frozen = (state == RUN) ? (mem_req && !mem_ready) : !mem_ready;
  always_comb begin
    nstate = state;
    nhold = hold;
    nwcnt = wcnt;
    nto = mem_timeout;
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} = '0;
    if (state == HOLD) begin
      {if_id_flush, id_ex_flush} = 2'b11;
      nhold = (hold != '0) ? hold - 1'b1 : hold;
      nstate = (hold == '0) ? RUN : HOLD;
    end else if (state == ERROR) begin
      nstate = ERROR;
    end else if (frozen) begin
      nwcnt = (state == RUN) ? WW'(1) : wcnt + 1'b1;
      nto = (state == MEM_WAIT && wcnt == WW'(MAX_WAIT)) || mem_timeout;
      nstate = nto ? ERROR : MEM_WAIT;
    end else begin
      nstate = RUN;
      {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
      {pc_en, if_id_en} = load_use ? 2'b00 : 2'b11;
      id_ex_flush = load_use || ex_branch_taken;
      if_id_flush = !load_use && ex_branch_taken;
    end
  end
  assign ncnt = (!pc_en && state != HOLD && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with directed hazard scenarios and randomized traffic.
module tb_pipe_hazard_ctrl;
  localparam int RST_HOLD = 2;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 5;
  localparam int SAT      = (1 << CNT_W) - 1;
  typedef struct packed {
    logic [6:0]       c;
    logic [CNT_W-1:0] s;
    logic             t;
  } exp_t;
  logic clk = 0, arst_n = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic ex_mem_read = 0, ex_branch_taken = 0, mem_req = 0, mem_ready = 1;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_hold, m_low, m_stall;
  bit m_wait, m_err;
  pipe_hazard_ctrl #(.RST_HOLD(RST_HOLD), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  // output order {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  task automatic do_reset();
    @(posedge clk); #1;
    arst_n = 0;
    m_hold = RST_HOLD; m_low = 0; m_stall = 0; m_wait = 0; m_err = 0;
    q.push_back('{c: 7'b0000011, s: '0, t: 1'b0});
  endtask
  task automatic drive(input logic [4:0] r1, r2, rd, input logic mr, br, rq, rdy);
    exp_t e;
    bit hold_now, lu;
    @(posedge clk); #1;
    arst_n = 1;
    id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
    ex_mem_read = mr; ex_branch_taken = br; mem_req = rq; mem_ready = rdy;
    e.s = CNT_W'(m_stall);
    e.t = m_err;
    hold_now = m_hold > 0;
    if (hold_now) begin
      e.c = 7'b0000011;
      m_hold--;
    end else if (m_err) e.c = '0;
    else if (m_wait ? !rdy : (rq && !rdy)) begin
      e.c = '0;
      m_low = m_wait ? m_low + 1 : 1;
      if (m_low == MAX_WAIT + 1) m_err = 1;
      m_wait = 1;
    end else begin
      m_wait = 0;
      lu = mr && rd != 0 && (rd == r1 || rd == r2);
      e.c = lu ? 7'b0011101 : br ? 7'b1111111 : 7'b1111100;
    end
    if (!e.c[6] && !hold_now && m_stall < SAT) m_stall++;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp += 3;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} !== e.c) begin
        n_bad++;
        $display("FAIL ctrl cyc=%0d got=%b exp=%b", cyc,
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}, e.c);
      end
      if (stall_cnt !== e.s) begin
        n_bad++;
        $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, e.s);
      end
      if (mem_timeout !== e.t) begin
        n_bad++;
        $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", cyc, mem_timeout, e.t);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    idle(5);
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    repeat (3) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    repeat (2) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    repeat (2) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle(3);
    repeat (8) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 249) do_reset();
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) < 6));
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
